// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with a small input FIFO, paced by an external baud_tick
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 baud_tick,
    input  logic [DATA_BITS-1:0]                 tx_data,
    input  logic                                 tx_valid,
    output logic                                 tx_ready,
    output logic                                 tx,
    output logic                                 busy,
    output logic                                 tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_stop_cnt;
    logic                 r_tx;
    logic                 r_done;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_par;
    state_t               w_state_nx;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic                 w_par_nx;
    logic [IW-1:0]        w_bit_idx_nx;
    logic                 w_stop_cnt_nx;
    logic                 w_tx_nx;
    logic                 w_done_nx;

    // Ready and empty both come from the registered count, so a full FIFO
    // refuses a push even when a pop happens in the same cycle.
    assign tx_ready   = (r_count < DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_push     = tx_valid && tx_ready;
    assign w_rd_data  = r_mem[r_rd_ptr];
    assign w_par      = (PARITY_ODD != 0) ? ~^w_rd_data : ^w_rd_data;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign tx_done    = r_done;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_par      <= w_par_nx;
            r_bit_idx  <= w_bit_idx_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_tx       <= w_tx_nx;
            r_done     <= w_done_nx;
        end
    end

    // The shift register holds the not-yet-sent bits; its LSB is always the next data bit.
    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_par_nx      = r_par;
        w_bit_idx_nx  = r_bit_idx;
        w_stop_cnt_nx = r_stop_cnt;
        w_tx_nx       = r_tx;
        w_done_nx     = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nx = 1'b1;
                if (baud_tick && !w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_rd_data;
                    w_par_nx   = w_par;
                    w_tx_nx    = 1'b0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    w_tx_nx      = r_shift[0];
                    w_shift_nx   = r_shift >> 1;
                    w_bit_idx_nx = '0;
                    w_state_nx   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (r_bit_idx != LAST_IDX) begin
                        w_bit_idx_nx = r_bit_idx + IW'(1);
                        w_tx_nx      = r_shift[0];
                        w_shift_nx   = r_shift >> 1;
                    end else begin
                        w_stop_cnt_nx = 1'b0;
                        if (PARITY_EN != 0) begin
                            w_tx_nx    = r_par;
                            w_state_nx = S_PARITY;
                        end else begin
                            w_tx_nx    = 1'b1;
                            w_state_nx = S_STOP;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    w_tx_nx       = 1'b1;
                    w_stop_cnt_nx = 1'b0;
                    w_state_nx    = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (r_stop_cnt != STOP_LAST) begin
                        w_stop_cnt_nx = r_stop_cnt + 1'b1;
                    end else begin
                        w_done_nx = 1'b1;
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_shift_nx = w_rd_data;
                            w_par_nx   = w_par;
                            w_tx_nx    = 1'b0;
                            w_state_nx = S_START;
                        end else begin
                            w_tx_nx    = 1'b1;
                            w_state_nx = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule
